// File: rtl/rf_writeback_queue.sv
// Write-back queue in front of the register file: buffers WB results and retires one per cycle.
// Define WBQ_BYPASS_EN to build the newest-pending-value lookup ports. Without it, BPH*/BPD* read 0.
module rf_writeback_queue #(
   parameter int AWL          = 5,
   parameter int DWL          = 32,
   parameter int DEPTH        = 4,
   parameter int ZERO_PROTECT = 1,
   localparam int PW          = $clog2(DEPTH),
   localparam int CW          = PW + 1
) (
   input  logic           CLK,
   input  logic           RSTN,
   input  logic           WBV,
   output logic           WBR,
   input  logic [AWL-1:0] WBA,
   input  logic [DWL-1:0] WBD,
   output logic           RFWE,
   output logic [AWL-1:0] RFWA,
   output logic [DWL-1:0] RFWD,
   output logic [CW-1:0]  QCNT,
   output logic           QEMPTY,
   input  logic [AWL-1:0] BPA1,
   input  logic [AWL-1:0] BPA2,
   output logic           BPH1,
   output logic           BPH2,
   output logic [DWL-1:0] BPD1,
   output logic [DWL-1:0] BPD2
);

   typedef struct packed {
      logic [AWL-1:0] addr;
      logic [DWL-1:0] data;
   } entry_t;

   entry_t         mem_q [DEPTH];
   entry_t         mem_d [DEPTH];
   logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           rfwe_q, rfwe_d;
   logic [AWL-1:0] rfwa_q, rfwa_d;
   logic [DWL-1:0] rfwd_q, rfwd_d;
   logic           push, store, pop;

   // Handshake: a request transfers on a posedge where WBV && WBR. WBR is a
   // function of reset and the registered count only, never of WBV or a pop.
   assign WBR    = RSTN && (cnt_q < CW'(DEPTH));
   assign RFWE   = rfwe_q;
   assign RFWA   = rfwa_q;
   assign RFWD   = rfwd_q;
   assign QCNT   = cnt_q;
   assign QEMPTY = (cnt_q == '0) && !rfwe_q;

   always_comb begin
      push   = WBV && WBR;
      store  = push && !((ZERO_PROTECT != 0) && (WBA == '0));
      pop    = (cnt_q != '0);
      mem_d  = mem_q;
      tail_d = tail_q;
      head_d = head_q;
      cnt_d  = cnt_q;
      rfwe_d = 1'b0;
      rfwa_d = rfwa_q;
      rfwd_d = rfwd_q;
      if (store) begin
         mem_d[tail_q] = '{addr: WBA, data: WBD};
         tail_d        = tail_q + 1'b1;
      end
      if (pop) begin
         rfwe_d = 1'b1;
         rfwa_d = mem_q[head_q].addr;
         rfwd_d = mem_q[head_q].data;
         head_d = head_q + 1'b1;
      end
      case ({store, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         rfwe_q <= 1'b0;
         rfwa_q <= '0;
         rfwd_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         rfwe_q <= rfwe_d;
         rfwa_q <= rfwa_d;
         rfwd_q <= rfwd_d;
      end
   end

   // Storage is only meaningful between head and tail, so it carries no reset.
   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

`ifdef WBQ_BYPASS_EN
   // Scan oldest to newest so the newest match overrides; the output register is lowest priority.
   function automatic logic [DWL:0] bp_lookup(input logic [AWL-1:0] a);
      logic [DWL:0]  r;
      logic [PW-1:0] idx;
      r = '0;
      if (rfwe_q && (rfwa_q == a)) r = {1'b1, rfwd_q};
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if ((CW'(i) < cnt_q) && (mem_q[idx].addr == a)) r = {1'b1, mem_q[idx].data};
      end
      if (a == '0) r = '0;
      return r;
   endfunction

   always_comb begin
      {BPH1, BPD1} = bp_lookup(BPA1);
      {BPH2, BPD2} = bp_lookup(BPA2);
   end
`else
   logic unused_bpa;
   assign unused_bpa = ^{BPA1, BPA2};
   assign BPH1 = 1'b0;
   assign BPH2 = 1'b0;
   assign BPD1 = '0;
   assign BPD2 = '0;
`endif

endmodule
